regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Writer end of the 32x32 register-file write port: sole driver of the file's a3/wd3/we3 inputs.
- Merges two result sources into that single port:
  - single-cycle ALU results, which have priority and no backpressure;
  - multi-cycle load results, which use a valid/ready handshake and are buffered in a small in-order FIFO.
- Also answers a pending-write query so decode can stall on read-after-write and write-after-write hazards against buffered loads.

Parameters:
- DEPTH, 4, load FIFO entries; power of 2, >= 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result can be accepted.
- ld_rd  in  AW  load destination register.
- ld_data  in  DW  load result.
- q_addr  in  AW  register being queried by decode.
- q_busy  out  1  a write to q_addr is pending in this block.
- a3  out  AW  register-file write address (registered).
- wd3  out  DW  register-file write data (registered).
- we3  out  1  register-file write enable (registered).
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset:
- Asynchronous reset clears: we3=0, a3=0, wd3=0, wr_ptr=0, rd_ptr=0, count=0.
- Hence ld_ready=1 and q_busy=0 during and after reset.
- Reset mid-operation discards all buffered loads and any staged write; nothing is written to the register file.

Handshake:
- ld_ready = (count != DEPTH), combinational from count only.
- A load transfers when ld_valid && ld_ready in a cycle.
- A full FIFO never accepts a load, even if a pop occurs that same cycle.

x0 suppression:
- ALU result with alu_rd==0 is ignored.
- Accepted load with ld_rd==0 completes the handshake but is not stored.
- we3 is therefore never asserted with a3==0.

Write selection (evaluated each cycle; result registered into a3/wd3/we3 at the edge):
1. ALU wins: alu_valid && alu_rd!=0 -> stage the ALU write.
2. Else, if the FIFO is non-empty -> pop the head and stage it.
3. Else, if a load is accepted this cycle with ld_rd!=0 -> stage it directly (bypass, no FIFO entry).
4. Else -> we3=0; a3/wd3 hold their previous values.

Latency and ordering:
- Latency from source to we3: 1 cycle for ALU writes and bypassed loads; FIFO loads wait until no ALU write is present.
- Loads leave the block in acceptance order.
- An ALU write may overtake older buffered loads. Decode prevents WAW/RAW via q_busy.

FIFO:
- Circular buffer with pointers wrapping modulo DEPTH.
- Same-cycle push and pop leaves count unchanged; both pointers advance.
- Push when count==DEPTH is impossible, since ld_ready is low.
- Pop only when count>0.

q_busy:
- q_addr!=0 AND either:
  - any valid FIFO entry has rd==q_addr; or
  - we3 && a3==q_addr (staged write not yet committed by the register file).
- Combinational; does not look at the current-cycle ALU or load inputs.

Synthesis:
- No combinational path from alu_* or ld_* inputs to a3/wd3/we3.

Decomposition:
- Shared package holds:
  - AW/DW defaults;
  - constant REG_ZERO = 0;
  - write-request struct/typedef {rd[AW], data[DW]}, reused by future forwarding logic.
- Sub-module wb_fifo: generic DEPTH x (AW+DW) synchronous FIFO with async reset. Exposes count, push, pop, head, and a flat entry/valid vector used for the q_busy compare.
- The top level contains only the selection mux, the output registers and q_busy.

Test Plan:
1. Reset, then alu_valid=1, rd=7, data=0xDEADBEEF for one cycle -> next cycle we3=1, a3=7, wd3=0xDEADBEEF; the cycle after, we3=0.
2. ALU writes rd=3 for 6 consecutive cycles while loads rd=10..15 are offered (ld_valid=1 held):
   - ld_ready falls after 4 accepts (fifo_count=4); loads rd=10..13 are buffered.
   - When ALU stops, we3 writes 10, 11, 12, 13 on successive cycles, with ld_ready rising after the first pop.
   - Then 14 and 15 are accepted and written in order.
3. Empty FIFO, no ALU, load rd=5, data=0x55 accepted -> next cycle we3=1, a3=5, wd3=0x55 (bypass); fifo_count stays 0.
4. ALU rd=0 and load rd=0 accepted -> we3 stays 0 and fifo_count stays 0; ld_ready stays 1.
5. FIFO holds rd=9 with ALU busy, q_addr=9 -> q_busy=1; q_addr=0 -> q_busy=0; after the rd=9 write commits -> q_busy=0.
6. FIFO at fifo_count=3, assert rst asynchronously mid-cycle -> immediately we3=0, fifo_count=0, ld_ready=1; no further writes after release.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared widths, x0 constant and write-request type
package regfile_writeback_pkg;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW_DEF-1:0] rd;
    logic [DW_DEF-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - result sources, hazard query and register-file write port
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
);
  logic                    alu_valid;
  logic [AW-1:0]           alu_rd;
  logic [DW-1:0]           alu_data;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [AW-1:0]           ld_rd;
  logic [DW-1:0]           ld_data;
  logic [AW-1:0]           q_addr;
  logic                    q_busy;
  logic [AW-1:0]           a3;
  logic [DW-1:0]           wd3;
  logic                    we3;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_addr,
    input  ld_ready, q_busy, a3, wd3, we3, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_addr,
    output ld_ready, q_busy, a3, wd3, we3, fifo_count
  );
endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// rtl/regfile_writeback_wb_fifo.sv - in-order circular FIFO exposing per-entry keys for hazard lookup
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  parameter int KW    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head,
  output logic [$clog2(DEPTH):0]  count,
  output logic [DEPTH*KW-1:0]     entries,
  output logic [DEPTH-1:0]        valid
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign entries[i*KW +: KW] = mem[i][W-1 -: KW];
    assign valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
  end
endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges ALU and buffered load results onto the register-file write port
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_writeback_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW+DW-1:0]    head;
  logic [CW-1:0]       count;
  logic [DEPTH*AW-1:0] entries;
  logic [DEPTH-1:0]    valid;
  logic                alu_sel;
  logic                ld_acc;
  logic                pop;
  logic                bypass;
  logic                push;
  logic                hit;
  logic [AW-1:0]       a3;
  logic [DW-1:0]       wd3;
  logic                we3;

  assign bus.ld_ready   = (count != CW'(DEPTH));
  assign bus.fifo_count = count;

  assign alu_sel = bus.alu_valid && (bus.alu_rd != AW'(REG_ZERO));
  assign ld_acc  = bus.ld_valid && bus.ld_ready;
  assign pop     = !alu_sel && (count != '0);
  assign bypass  = !alu_sel && (count == '0) && ld_acc && (bus.ld_rd != AW'(REG_ZERO));
  // x0 loads complete the handshake but never occupy an entry.
  assign push    = ld_acc && (bus.ld_rd != AW'(REG_ZERO)) && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW),
    .KW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.ld_rd, bus.ld_data}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .entries   (entries),
    .valid     (valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (alu_sel) begin
      we3 <= 1'b1;
      a3  <= bus.alu_rd;
      wd3 <= bus.alu_data;
    end else if (pop) begin
      we3 <= 1'b1;
      a3  <= head[AW+DW-1 -: AW];
      wd3 <= head[DW-1:0];
    end else if (bypass) begin
      we3 <= 1'b1;
      a3  <= bus.ld_rd;
      wd3 <= bus.ld_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  assign bus.a3  = a3;
  assign bus.wd3 = wd3;
  assign bus.we3 = we3;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i*AW +: AW] == bus.q_addr)) hit = 1'b1;
    end
  end

  // The staged write still counts as pending until the register file has taken it.
  assign bus.q_busy = (bus.q_addr != AW'(REG_ZERO)) && (hit || (we3 && (a3 == bus.q_addr)));
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic    we;
    wr_req_t w;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_if #(.DEPTH(DEPTH), .AW(AW_DEF), .DW(DW_DEF)) bus ();

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW_DEF), .DW(DW_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int      checks = 0;
  int      errors = 0;
  exp_t    sbq[$];
  wr_req_t mq[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        if (bus.we3 !== 1'b0) begin
          errors++;
          $display("FAIL sb_unexpected we3=%b a3=%0d required we3=0", bus.we3, bus.a3);
        end
      end else begin
        e = sbq.pop_front();
        checks++;
        if (bus.we3 !== e.we) begin
          errors++;
          $display("FAIL sb_we3 got %b required %b (a3=%0d)", bus.we3, e.we, bus.a3);
        end
        if (e.we) begin
          checks++;
          if (bus.a3 !== e.w.rd || bus.wd3 !== e.w.data) begin
            errors++;
            $display("FAIL sb_write got a3=%0d wd3=%h required a3=%0d wd3=%h",
                     bus.a3, bus.wd3, e.w.rd, e.w.data);
          end
        end
      end
    end
  end

  task automatic set_idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.q_addr    = '0;
  endtask

  // One clock of stimulus; reference model decides the write expected at the next edge.
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    exp_t e;
    logic acc;
    logic byp;
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ldd;
    acc  = lv && (mq.size() < DEPTH);
    byp  = 1'b0;
    e    = '0;
    if (av && ar != 5'd0) begin
      e.we = 1'b1;
      e.w  = '{rd: ar, data: ad};
    end else if (mq.size() > 0) begin
      e.we = 1'b1;
      e.w  = mq.pop_front();
    end else if (acc && lr != 5'd0) begin
      e.we = 1'b1;
      e.w  = '{rd: lr, data: ldd};
      byp  = 1'b1;
    end
    if (acc && lr != 5'd0 && !byp) mq.push_back('{rd: lr, data: ldd});
    @(posedge clk);
    sbq.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if (bus.we3 !== 1'b0 || bus.a3 !== 5'd0 || bus.wd3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got we3=%b a3=%0d wd3=%h required 0/0/0", bus.we3, bus.a3, bus.wd3);
    end
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.q_busy !== 1'b0 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_status got ld_ready=%b q_busy=%b count=%0d required 1/0/0",
               bus.ld_ready, bus.q_busy, bus.fifo_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_single();
    drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd7 || bus.wd3 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_single got we3=%b a3=%0d wd3=%h required 1/7/deadbeef", bus.we3, bus.a3, bus.wd3);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.we3 !== 1'b0) begin
      errors++;
      $display("FAIL alu_single_clear got we3=%b required 0", bus.we3);
    end
  endtask

  task automatic test_alu_priority_backpressure();
    int idx = 0;
    for (int c = 0; c < 16; c++) begin
      logic lv;
      logic rdy;
      if (c == 4) begin
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.ld_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full got count=%0d ld_ready=%b required 4/0", bus.fifo_count, bus.ld_ready);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.ld_ready !== 1'b1 || bus.fifo_count !== 3'd3) begin
          errors++;
          $display("FAIL bp_reopen got ld_ready=%b count=%0d required 1/3", bus.ld_ready, bus.fifo_count);
        end
      end
      lv  = (idx < 6);
      rdy = bus.ld_ready;
      drive(c < 6, 5'd3, 32'(c), lv, 5'(10 + idx), 32'h100 + 32'(idx));
      if (lv && rdy) idx++;
    end
    checks++;
    if (idx != 6 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL bp_drain got accepted=%0d count=%0d required 6/0", idx, bus.fifo_count);
    end
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
    checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd5 || bus.wd3 !== 32'h55 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL bypass got we3=%b a3=%0d wd3=%h count=%0d required 1/5/55/0",
               bus.we3, bus.a3, bus.wd3, bus.fifo_count);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
    checks++;
    if (bus.we3 !== 1'b0 || bus.fifo_count !== 3'd0 || bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0 got we3=%b count=%0d ld_ready=%b required 0/0/1", bus.we3, bus.fifo_count, bus.ld_ready);
    end
  endtask

  task automatic test_q_busy();
    drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd9, 32'h99);
    bus.q_addr = 5'd9;
    #1;
    checks++;
    if (bus.q_busy !== 1'b1) begin
      errors++;
      $display("FAIL qbusy_fifo got %b required 1", bus.q_busy);
    end
    bus.q_addr = 5'd0;
    #1;
    checks++;
    if (bus.q_busy !== 1'b0) begin
      errors++;
      $display("FAIL qbusy_x0 got %b required 0", bus.q_busy);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.q_addr = 5'd9;
    #1;
    checks++;
    if (bus.q_busy !== 1'b1 || bus.a3 !== 5'd9) begin
      errors++;
      $display("FAIL qbusy_staged got q_busy=%b a3=%0d required 1/9", bus.q_busy, bus.a3);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.q_addr = 5'd9;
    #1;
    checks++;
    if (bus.q_busy !== 1'b0) begin
      errors++;
      $display("FAIL qbusy_commit got %b required 0", bus.q_busy);
    end
    bus.q_addr = 5'd0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      checks++;
      if (bus.fifo_count !== 3'(mq.size())) begin
        errors++;
        $display("FAIL rand_count got %0d required %0d", bus.fifo_count, mq.size());
      end
    end
    repeat (DEPTH + 2) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rand_drain got %0d required 0", bus.fifo_count);
    end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 3; k++) drive(1'b1, 5'd3, 32'(k), 1'b1, 5'(20 + k), 32'(k));
    checks++;
    if (bus.fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL midrst_fill got %0d required 3", bus.fifo_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.we3 !== 1'b0 || bus.fifo_count !== 3'd0 || bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst got we3=%b count=%0d ld_ready=%b required 0/0/1",
               bus.we3, bus.fifo_count, bus.ld_ready);
    end
    sbq.delete();
    mq.delete();
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.we3 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got count=%0d we3=%b required 0/0", bus.fifo_count, bus.we3);
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_alu_priority_backpressure();
    test_bypass();
    test_x0();
    test_q_busy();
    test_random();
    test_reset_midop();
    checks++;
    if (sbq.size() > 1) begin
      errors++;
      $display("FAIL sb_leftover got %0d required <=1", sbq.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
